fft_frame_sequencer: RTL and testbench
======================================

Name: fft_frame_sequencer

Overview:
Initiator side of the FFT start/done handshake. Collects microphone samples from a strobe into a sliding window and freezes a stable N-point snapshot for the FFT. It pulses start, waits for done, then latches the frequency-domain result for the magnitude/VGA path. Replaces the ad-hoc free-running start logic and the unguarded shift register in the top level; the whole block runs in the FFT clock domain.

Parameters:
N_PTS, 16, FFT points / window depth
SAMPLE_W, 16, microphone sample width
WORD_W, 32, FFT word width; a sample is packed as {sample, (WORD_W-SAMPLE_W) zeros}
HOP, 16, new samples between frame triggers; legal range 1..N_PTS
DONE_TIMEOUT, 1024, cycles allowed in WAIT_DONE before abort

Ports:
clk  in  1  single block clock (FFT clock)
rst  in  1  synchronous, active-low reset
sample_valid  in  1  one-cycle strobe; sample is valid this cycle
sample  in  SAMPLE_W  new time-domain sample
td  out  N_PTS x WORD_W  frozen snapshot to FFT; td[0] is newest
fft_start  out  1  one-cycle start pulse to FFT
fft_done  in  1  FFT completion level
fd_in  in  N_PTS x WORD_W  FFT result
fd_out  out  N_PTS x WORD_W  latched result for magnitude block
fd_valid  out  1  one-cycle pulse when fd_out updates
busy  out  1  high in START, WAIT_DONE and CAPTURE
skipped  out  8  saturating count of frame triggers dropped while busy
timeouts  out  8  saturating count of aborted frames

Behaviour:
- Reset: rst=0 at a clk edge clears all state. After that edge: window and td are zero, fd_out is zero, all counters are zero, state is IDLE, and fft_start, fd_valid and busy are 0. A reset in any state aborts the frame with no fd_valid pulse.
- Window: on sample_valid, shift entries up by one (window[i] <= window[i-1]) and load window[0] <= {sample, 0}.
- fill_cnt: saturates at N_PTS. No trigger fires until the window is full.
- hop_cnt: increments on sample_valid. The trigger fires in the cycle hop_cnt reaches HOP with fill_cnt == N_PTS; hop_cnt then resets to 0.
- Trigger with a same-cycle sample: the snapshot includes that sample (next-state window value).
- FSM:
  - IDLE: on trigger, td <= window (next-state), go to START.
  - START: fft_start=1 for exactly this cycle; clear the done_low_seen flag; go to WAIT_DONE.
  - WAIT_DONE: set done_low_seen when fft_done==0. When fft_done==1 and done_low_seen, go to CAPTURE. A done level left over from the previous frame is ignored until fft_done has been seen low.
  - CAPTURE: fd_out <= fd_in; fd_valid=1 this cycle; go to IDLE.
- Latency: trigger edge -> fft_start is 1 cycle. Accepted done edge -> fd_valid is 1 cycle.
- td changes only on IDLE->START, so it is stable for the whole FFT run.
- Trigger while busy: the frame is dropped and skipped increments (saturates at 255). The window keeps shifting.
- Back-to-back: a trigger in the same cycle CAPTURE returns to IDLE counts as skipped. IDLE accepts triggers from the next cycle.
- Counter rule: skipped and timeouts stay at 255 once reached.

Optional Feature:
FFT_SEQ_TIMEOUT_EN
- Defined: a cycle counter runs in WAIT_DONE. When it hits DONE_TIMEOUT, the FSM returns to IDLE, timeouts increments, fd_out is unchanged and there is no fd_valid pulse.
- Undefined: no counter; WAIT_DONE waits forever; the timeouts port is tied to 0.

Decomposition:
- Package fft_seq_pkg holds:
  - N_PTS, SAMPLE_W and WORD_W defaults
  - typedef word_t (logic [WORD_W-1:0])
  - typedef frame_t (word_t array [0:N_PTS-1])
  - enum seq_state_t {IDLE, START, WAIT_DONE, CAPTURE}
- One sub-module, sample_window_sr: the shift register plus fill_cnt and hop_cnt, with a trigger output. The FSM and result latch stay in the top of this block.

Test Plan:
- Reset, then 16 sample_valid strobes with samples 1..16 -> fft_start pulses once, 1 cycle after the 16th strobe; td[0]=32'h0010_0000, td[15]=32'h0001_0000.
- fft_done held 1 through START, dropped low 2 cycles, then raised with fd_in[k]=k -> CAPTURE only after the low phase; fd_valid 1 cycle later; fd_out[3]=3.
- HOP=4, FFT never answers, 20 further strobes -> skipped=5; td unchanged throughout WAIT_DONE.
- With FFT_SEQ_TIMEOUT_EN, DONE_TIMEOUT=8, no done -> IDLE after 8 WAIT cycles; timeouts=1; no fd_valid; the next trigger issues fft_start normally.
- rst=0 for one cycle during WAIT_DONE -> next cycle busy=0, fd_out=0, counters=0; with HOP=16, the next start comes only after 16 new strobes.
- sample_valid in the same cycle the trigger fires -> td[0] equals that sample; skipped stays 0.

Source files
------------

// File: rtl/fft_seq_pkg.sv
// rtl/fft_seq_pkg.sv - shared widths, frame types and FSM states for the FFT frame sequencer
package fft_seq_pkg;
  localparam int DEF_N_PTS    = 16;
  localparam int DEF_SAMPLE_W = 16;
  localparam int DEF_WORD_W   = 32;

  typedef logic [DEF_WORD_W-1:0] word_t;
  typedef word_t frame_t [0:DEF_N_PTS-1];

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, CAPTURE} seq_state_t;
endpackage

// File: rtl/sample_window_sr.sv
// rtl/sample_window_sr.sv - sliding sample window with fill/hop counters and frame trigger
module sample_window_sr #(
  parameter int N_PTS    = 16,
  parameter int SAMPLE_W = 16,
  parameter int WORD_W   = 32,
  parameter int HOP      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [WORD_W-1:0]   window_next [N_PTS],
  output logic                trigger
);
  localparam int FW = $clog2(N_PTS + 1);
  localparam int HW = $clog2(HOP + 1);

  logic [WORD_W-1:0] window [N_PTS];
  logic [FW-1:0]     fill_cnt;
  logic [FW-1:0]     fill_next;
  logic [HW-1:0]     hop_cnt;
  logic [HW-1:0]     hop_inc;

  // Trigger uses next-state counts so a same-cycle sample lands in the snapshot.
  always_comb begin
    window_next = window;
    fill_next   = fill_cnt;
    hop_inc     = hop_cnt + 1'b1;
    trigger     = 1'b0;
    if (sample_valid) begin
      for (int i = N_PTS - 1; i > 0; i--) window_next[i] = window[i-1];
      window_next[0] = {sample, {(WORD_W - SAMPLE_W){1'b0}}};
      if (fill_cnt != FW'(N_PTS)) fill_next = fill_cnt + 1'b1;
      trigger = (hop_inc == HW'(HOP)) && (fill_next == FW'(N_PTS));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      window   <= '{default: '0};
      fill_cnt <= '0;
      hop_cnt  <= '0;
    end else begin
      window   <= window_next;
      fill_cnt <= fill_next;
      if (sample_valid) hop_cnt <= (hop_inc == HW'(HOP)) ? '0 : hop_inc;
    end
  end
endmodule

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - FFT start/done initiator: snapshot window, run FFT, latch result
// FFT_SEQ_TIMEOUT_EN adds the DONE_TIMEOUT abort in WAIT_DONE and the timeouts counter.
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int N_PTS    = DEF_N_PTS,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int WORD_W   = DEF_WORD_W,
  parameter int HOP      = 16
`ifdef FFT_SEQ_TIMEOUT_EN
  , parameter int DONE_TIMEOUT = 1024
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [WORD_W-1:0]   td [N_PTS],
  output logic                fft_start,
  input  logic                fft_done,
  input  logic [WORD_W-1:0]   fd_in [N_PTS],
  output logic [WORD_W-1:0]   fd_out [N_PTS],
  output logic                fd_valid,
  output logic                busy,
  output logic [7:0]          skipped,
  output logic [7:0]          timeouts
);
  seq_state_t        state;
  logic              done_low_seen;
  logic              done_accept;
  logic              timed_out;
  logic              trigger;
  logic [WORD_W-1:0] window_next [N_PTS];

  sample_window_sr #(
    .N_PTS(N_PTS), .SAMPLE_W(SAMPLE_W), .WORD_W(WORD_W), .HOP(HOP)
  ) u_window (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
    .window_next(window_next), .trigger(trigger)
  );

  // A done level carried over from the previous frame only counts after a low phase.
  assign done_accept = (state == WAIT_DONE) && fft_done && done_low_seen;

`ifdef FFT_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;

  assign timed_out = (state == WAIT_DONE) && !done_accept && (wait_cnt == TW'(DONE_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
      timeouts <= '0;
    end else begin
      wait_cnt <= (state == WAIT_DONE) ? wait_cnt + 1'b1 : '0;
      if (timed_out && timeouts != 8'hFF) timeouts <= timeouts + 8'd1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign timeouts  = 8'd0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      td            <= '{default: '0};
      fd_out        <= '{default: '0};
      fft_start     <= 1'b0;
      fd_valid      <= 1'b0;
      busy          <= 1'b0;
      done_low_seen <= 1'b0;
      skipped       <= '0;
    end else begin
      fft_start <= 1'b0;
      fd_valid  <= 1'b0;
      if (trigger && state != IDLE && skipped != 8'hFF) skipped <= skipped + 8'd1;
      case (state)
        IDLE: begin
          if (trigger) begin
            td        <= window_next;
            fft_start <= 1'b1;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          done_low_seen <= 1'b0;
          state         <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!fft_done) done_low_seen <= 1'b1;
          if (done_accept) begin
            fd_out   <= fd_in;
            fd_valid <= 1'b1;
            state    <= CAPTURE;
          end else if (timed_out) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        CAPTURE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb/tb_fft_frame_sequencer.sv - self-checking bench for fft_frame_sequencer (HOP=16 and HOP=4 instances)
module tb_fft_frame_sequencer;
  import fft_seq_pkg::*;

  localparam int N     = DEF_N_PTS;
  localparam int HOP_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sv_a, sv_b, done_a, done_b;
  logic [15:0] smp;
  frame_t      fd_in, td_a, td_b, fdo_a, fdo_b;
  logic        st_a, st_b, fv_a, fv_b, busy_a, busy_b;
  logic [7:0]  skip_a, skip_b, to_a, to_b;
  int          n_cmp = 0;
  int          n_bad = 0;

  fft_frame_sequencer #(
    .HOP(16)
`ifdef FFT_SEQ_TIMEOUT_EN
    , .DONE_TIMEOUT(8)
`endif
  ) dut_a (
    .clk(clk), .rst(rst), .sample_valid(sv_a), .sample(smp), .td(td_a),
    .fft_start(st_a), .fft_done(done_a), .fd_in(fd_in), .fd_out(fdo_a),
    .fd_valid(fv_a), .busy(busy_a), .skipped(skip_a), .timeouts(to_a)
  );

  fft_frame_sequencer #(
    .HOP(HOP_B)
`ifdef FFT_SEQ_TIMEOUT_EN
    , .DONE_TIMEOUT(2000)
`endif
  ) dut_b (
    .clk(clk), .rst(rst), .sample_valid(sv_b), .sample(smp), .td(td_b),
    .fft_start(st_b), .fft_done(done_b), .fd_in(fd_in), .fd_out(fdo_b),
    .fd_valid(fv_b), .busy(busy_b), .skipped(skip_b), .timeouts(to_b)
  );

  function automatic word_t pk(input logic [15:0] s);
    return {s, 16'h0000};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b0; sv_a = 1'b0; sv_b = 1'b0; done_a = 1'b1; done_b = 1'b1; smp = '0;
    fd_in = '{default: '0};
    step(); step();
    n_cmp++;
    if ({busy_a, st_a, fv_a, busy_b, st_b, fv_b} !== 6'b0 || skip_a !== 0 || to_a !== 0 || skip_b !== 0) begin
      n_bad++; $display("FAIL reset_flags busy/start/valid a=%b%b%b b=%b%b%b skip=%0d to=%0d, want all 0",
                        busy_a, st_a, fv_a, busy_b, st_b, fv_b, skip_a, to_a);
    end
    bad = 0;
    for (int k = 0; k < N; k++) if (td_a[k] !== 0 || fdo_a[k] !== 0 || td_b[k] !== 0) bad++;
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL reset_arrays nonzero words=%0d, want 0", bad); end
    rst = 1'b1;
  endtask

  task automatic test_fill_start();
    int bad;
    for (int i = 1; i <= 16; i++) begin
      sv_a = 1'b1; smp = 16'(i);
      step();
      n_cmp++;
      if (st_a !== (i == 16)) begin n_bad++; $display("FAIL fill_start strobe %0d fft_start=%b want %b", i, st_a, i == 16); end
    end
    sv_a = 1'b0;
    n_cmp++;
    if (td_a[0] !== 32'h0010_0000 || td_a[15] !== 32'h0001_0000) begin
      n_bad++; $display("FAIL fill_td_ends td0=%h td15=%h want 00100000/00010000", td_a[0], td_a[15]);
    end
    bad = 0;
    for (int k = 0; k < N; k++) if (td_a[k] !== pk(16'(16 - k))) bad++;
    n_cmp++;
    if (bad != 0 || skip_a !== 0 || busy_a !== 1) begin
      n_bad++; $display("FAIL fill_snapshot bad=%0d skipped=%0d busy=%b want 0/0/1", bad, skip_a, busy_a);
    end
  endtask

  task automatic test_done_handshake();
    int bad;
    step();
    n_cmp++;
    if (st_a !== 0 || busy_a !== 1) begin n_bad++; $display("FAIL start_once fft_start=%b busy=%b want 0/1", st_a, busy_a); end
    step();
    n_cmp++;
    if (fv_a !== 0) begin n_bad++; $display("FAIL stale_done fd_valid=%b want 0", fv_a); end
    done_a = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++;
      if (fv_a !== 0 || busy_a !== 1) begin n_bad++; $display("FAIL low_phase fd_valid=%b busy=%b want 0/1", fv_a, busy_a); end
    end
    done_a = 1'b1;
    for (int k = 0; k < N; k++) fd_in[k] = 32'(k);
    step();
    n_cmp++;
    if (fv_a !== 1 || fdo_a[3] !== 32'd3) begin n_bad++; $display("FAIL capture fd_valid=%b fd_out3=%0d want 1/3", fv_a, fdo_a[3]); end
    for (int k = 0; k < N; k++) fd_in[k] = $urandom;
    step();
    bad = 0;
    for (int k = 0; k < N; k++) if (fdo_a[k] !== 32'(k)) bad++;
    n_cmp++;
    if (fv_a !== 0 || busy_a !== 0 || bad != 0) begin
      n_bad++; $display("FAIL post_capture fd_valid=%b busy=%b bad=%0d want 0/0/0", fv_a, busy_a, bad);
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    for (int i = 1; i <= 16; i++) begin
      sv_a = 1'b1; smp = 16'($urandom);
      step();
      n_cmp++;
      if (st_a !== (i == 16)) begin n_bad++; $display("FAIL refill strobe %0d fft_start=%b want %b", i, st_a, i == 16); end
    end
    sv_a = 1'b0; done_a = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    bad = 0;
    for (int k = 0; k < N; k++) if (fdo_a[k] !== 0 || td_a[k] !== 0) bad++;
    n_cmp++;
    if (busy_a !== 0 || fv_a !== 0 || st_a !== 0 || skip_a !== 0 || to_a !== 0 || bad != 0) begin
      n_bad++; $display("FAIL mid_reset busy=%b valid=%b start=%b skip=%0d to=%0d bad=%0d want all 0",
                        busy_a, fv_a, st_a, skip_a, to_a, bad);
    end
    for (int i = 1; i <= 16; i++) begin
      sv_a = 1'b1; smp = 16'($urandom);
      step();
      n_cmp++;
      if (st_a !== (i == 16)) begin n_bad++; $display("FAIL post_reset_fill strobe %0d fft_start=%b want %b", i, st_a, i == 16); end
    end
    sv_a = 1'b0;
  endtask

  task automatic test_timeout();
    int bad;
    rst = 1'b0; step(); rst = 1'b1; done_a = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      sv_a = 1'b1; smp = 16'(i + 100);
      step();
      n_cmp++;
      if (st_a !== (i == 16)) begin n_bad++; $display("FAIL to_fill strobe %0d fft_start=%b want %b", i, st_a, i == 16); end
    end
    sv_a = 1'b0;
`ifdef FFT_SEQ_TIMEOUT_EN
    for (int c = 1; c <= 9; c++) begin
      step();
      n_cmp++;
      if (busy_a !== (c <= 8) || fv_a !== 0) begin
        n_bad++; $display("FAIL timeout_wait cycle %0d busy=%b fd_valid=%b want %b/0", c, busy_a, fv_a, c <= 8);
      end
    end
    n_cmp++;
    if (to_a !== 8'd1) begin n_bad++; $display("FAIL timeout_count timeouts=%0d want 1", to_a); end
    for (int i = 1; i <= 16; i++) begin
      sv_a = 1'b1; smp = 16'(i);
      step();
      n_cmp++;
      if (st_a !== (i == 16)) begin n_bad++; $display("FAIL after_timeout strobe %0d fft_start=%b want %b", i, st_a, i == 16); end
    end
    sv_a = 1'b0;
`else
    bad = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (busy_a !== 1 || fv_a !== 0) bad++;
    end
    n_cmp++;
    if (bad != 0 || to_a !== 0) begin n_bad++; $display("FAIL wait_forever bad_cycles=%0d timeouts=%0d want 0/0", bad, to_a); end
`endif
  endtask

  task automatic test_skip();
    frame_t saved;
    int     bad;
    rst = 1'b0; step(); rst = 1'b1; done_b = 1'b0;
    bad = 0;
    for (int i = 1; i <= 16; i++) begin
      sv_b = 1'b1; smp = 16'($urandom);
      saved[16 - i] = pk(smp);
      step();
      if (st_b !== (i == 16)) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL hop4_first_start bad_strobes=%0d want 0", bad); end
    bad = 0;
    for (int i = 1; i <= 20; i++) begin
      sv_b = 1'b1; smp = 16'($urandom);
      step();
      if (st_b !== 0) bad++;
      for (int k = 0; k < N; k++) if (td_b[k] !== saved[k]) bad++;
    end
    sv_b = 1'b0;
    n_cmp++;
    if (bad != 0 || skip_b !== 8'd5) begin n_bad++; $display("FAIL skip_hold bad=%0d skipped=%0d want 0/5", bad, skip_b); end
    done_b = 1'b1;
    step();
    n_cmp++;
    if (fv_b !== 1) begin n_bad++; $display("FAIL skip_finish fd_valid=%b want 1", fv_b); end
    step();
    n_cmp++;
    if (busy_b !== 0) begin n_bad++; $display("FAIL skip_idle busy=%b want 0", busy_b); end
  endtask

  task automatic test_saturation();
    done_b = 1'b0;
    for (int i = 0; i < 1100; i++) begin sv_b = 1'b1; smp = 16'(i); step(); end
    n_cmp++;
    if (skip_b !== 8'd255) begin n_bad++; $display("FAIL skip_saturate skipped=%0d want 255", skip_b); end
    for (int i = 0; i < 8; i++) step();
    sv_b = 1'b0;
    n_cmp++;
    if (skip_b !== 8'd255) begin n_bad++; $display("FAIL skip_stay skipped=%0d want 255", skip_b); end
  endtask

  task automatic test_random();
    word_t  hist[$];
    frame_t exp_td, exp_fd;
    int     k_tot, m_skip, rt, w, l, bad;
    bit     resp_on, cap;
    rst = 1'b0; sv_b = 1'b0; step(); rst = 1'b1;
    exp_td = '{default: '0}; exp_fd = '{default: '0};
    k_tot = 0; m_skip = 0; resp_on = 0; cap = 0; rt = 0; w = 0; l = 1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bit trig, acc, exp_st, exp_fv, exp_busy;
      sv_b = ($urandom_range(0, 2) != 0);
      smp  = 16'($urandom);
      for (int k = 0; k < N; k++) fd_in[k] = $urandom;
      acc = 0;
      if (resp_on) begin
        if (rt <= w) done_b = 1'b1;
        else if (rt <= w + l) done_b = 1'b0;
        else begin done_b = 1'b1; acc = 1; end
      end else begin
        done_b = 1'($urandom_range(0, 1));
      end
      step();
      if (sv_b) begin hist.push_front(pk(smp)); k_tot++; end
      if (hist.size() > N) void'(hist.pop_back());
      trig = sv_b && k_tot >= N && (k_tot % HOP_B) == 0;
      exp_st = 0; exp_fv = 0;
      if (trig) begin
        if (resp_on || cap) begin if (m_skip < 255) m_skip++; end
        else begin exp_st = 1; for (int k = 0; k < N; k++) exp_td[k] = hist[k]; end
      end
      if (acc) begin exp_fv = 1; exp_fd = fd_in; end
      cap = acc;
      if (acc) resp_on = 0;
      else if (resp_on) rt++;
      if (exp_st) begin resp_on = 1; rt = 0; w = $urandom_range(0, 2); l = $urandom_range(1, 3); end
      exp_busy = resp_on || cap;
      bad = 0;
      for (int k = 0; k < N; k++) begin
        if (td_b[k] !== exp_td[k]) bad++;
        if (fdo_b[k] !== exp_fd[k]) bad++;
      end
      n_cmp++;
      if (st_b !== exp_st || fv_b !== exp_fv || busy_b !== exp_busy || skip_b !== 8'(m_skip) || bad != 0) begin
        n_bad++;
        $display("FAIL random cyc %0d start=%b/%b valid=%b/%b busy=%b/%b skipped=%0d/%0d bad_words=%0d (got/want)",
                 cyc, st_b, exp_st, fv_b, exp_fv, busy_b, exp_busy, skip_b, m_skip, bad);
      end
    end
    sv_b = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_start();
    test_done_handshake();
    test_reset_mid_frame();
    test_timeout();
    test_skip();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
